// File: rtl/sort_engine_param_pkg.sv
// Shared types and default widths for the register-file exchange sorter.
package sort_engine_param_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMP  = 3'd1,
        WR1  = 3'd2,
        WR2  = 3'd3,
        ADV  = 3'd4,
        DONE = 3'd5
    } sort_state_t;

endpackage

// File: rtl/sort_engine_param_if.sv
// Control, status and register-file bus of the sorter; master is the engine side.
interface sort_engine_param_if
    import sort_engine_param_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              exe;
    logic              desc;
    logic              sgn;
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] hi;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [ADDR_W-1:0] add0;
    logic [ADDR_W-1:0] add1;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  cycles;
    logic [CNT_W-1:0]  swaps;

    modport master (
        input  exe, desc, sgn, lo, hi, data0, data1,
        output add0, add1, we, wa, wd, busy, done, cycles, swaps
    );

    modport slave (
        output exe, desc, sgn, lo, hi, data0, data1,
        input  add0, add1, we, wa, wd, busy, done, cycles, swaps
    );
endinterface

// File: rtl/sort_engine_param_cmp.sv
// Out-of-order test for a pair (a at lower address, b at higher); strict, so ties never swap.
module sort_engine_param_cmp #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sgn_i,
    input  logic              desc_i,
    output logic              ooo_o
);
    logic a_gt_b;
    logic a_lt_b;

    always_comb begin
        if (sgn_i) begin
            a_gt_b = $signed(a_i) > $signed(b_i);
            a_lt_b = $signed(a_i) < $signed(b_i);
        end else begin
            a_gt_b = a_i > b_i;
            a_lt_b = a_i < b_i;
        end
        ooo_o = desc_i ? a_lt_b : a_gt_b;
    end
endmodule

// File: rtl/sort_engine_param.sv
// In-place exchange sort over a window [lo..hi] of an external register file
// with two combinational read ports and one registered write port.
module sort_engine_param
    import sort_engine_param_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    sort_engine_param_if.master bus
);
    sort_state_t       state_q, state_d;
    logic [ADDR_W-1:0] add0_q, add0_d, add1_q, add1_d;
    logic [ADDR_W-1:0] wa_q, wa_d, hi_q, hi_d;
    logic [DATA_W-1:0] wd_q, wd_d, t0_q, t0_d;
    logic              we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic              desc_q, desc_d, sgn_q, sgn_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d, swaps_q, swaps_d;
    logic              ooo;
    logic              last_pair;

    sort_engine_param_cmp #(.DATA_W(DATA_W)) u_cmp (
        .a_i    (bus.data0),
        .b_i    (bus.data1),
        .sgn_i  (sgn_q),
        .desc_i (desc_q),
        .ooo_o  (ooo)
    );

    assign last_pair = (add1_q == hi_q) && (add0_q == hi_q - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            add0_q   <= '0;
            add1_q   <= '0;
            wa_q     <= '0;
            hi_q     <= '0;
            wd_q     <= '0;
            t0_q     <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            desc_q   <= 1'b0;
            sgn_q    <= 1'b0;
            cycles_q <= '0;
            swaps_q  <= '0;
        end else begin
            state_q  <= state_d;
            add0_q   <= add0_d;
            add1_q   <= add1_d;
            wa_q     <= wa_d;
            hi_q     <= hi_d;
            wd_q     <= wd_d;
            t0_q     <= t0_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            desc_q   <= desc_d;
            sgn_q    <= sgn_d;
            cycles_q <= cycles_d;
            swaps_q  <= swaps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.exe) state_d = (bus.lo >= bus.hi) ? DONE : CMP;
            CMP:     state_d = ooo ? WR1 : ADV;
            WR1:     state_d = WR2;
            WR2:     state_d = ADV;
            ADV:     state_d = last_pair ? DONE : CMP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        add0_d   = add0_q;
        add1_d   = add1_q;
        wa_d     = wa_q;
        hi_d     = hi_q;
        wd_d     = wd_q;
        t0_d     = t0_q;
        we_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        desc_d   = desc_q;
        sgn_d    = sgn_q;
        swaps_d  = swaps_q;
        cycles_d = busy_q ? cycles_q + 1'b1 : cycles_q;
        case (state_q)
            IDLE: begin
                if (bus.exe) begin
                    desc_d   = bus.desc;
                    sgn_d    = bus.sgn;
                    hi_d     = bus.hi;
                    cycles_d = '0;
                    swaps_d  = '0;
                    busy_d   = 1'b1;
                    if (bus.lo < bus.hi) begin
                        add0_d = bus.lo;
                        add1_d = bus.lo + 1'b1;
                    end
                end
            end
            CMP: begin
                if (ooo) begin
                    we_d    = 1'b1;
                    wa_d    = add0_q;
                    wd_d    = bus.data1;
                    t0_d    = bus.data0;
                    swaps_d = swaps_q + 1'b1;
                end
            end
            WR1: begin
                we_d = 1'b1;
                wa_d = add1_q;
                wd_d = t0_q;
            end
            ADV: begin
                // Inner index runs to hi, then the outer index steps and the inner restarts just past it.
                if (add1_q != hi_q) begin
                    add1_d = add1_q + 1'b1;
                end else if (!last_pair) begin
                    add0_d = add0_q + 1'b1;
                    add1_d = add0_q + 2'd2;
                end
            end
            DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.add0   = add0_q;
    assign bus.add1   = add1_q;
    assign bus.we     = we_q;
    assign bus.wa     = wa_q;
    assign bus.wd     = wd_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.cycles = cycles_q;
    assign bus.swaps  = swaps_q;
endmodule
